// File: rtl/car_defs_pkg.sv
// Shared drive-controller definitions: engine state encodings used by the
// manual, auto and semi-auto drive blocks.
package car_defs_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_NOT_STARTING = 2'b00,
    ST_STARTING     = 2'b01,
    ST_MOVING       = 2'b10
  } drive_state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running cycle divider: counts 0..MAX-1 while run is high and flags the
// last count with a one-cycle tick. clr restarts the count from zero.
module tick_divider #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] cnt;

  assign tick = run & ~clr & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/manual_drive_ctrl.sv
// Manual-transmission drive controller: engine FSM, gear latch, stall
// requests, motion/turn commands, blinking turn LEDs and odometer.
//
//   state            | meaning
//   -----------------+-------------------------------------------------
//   ST_NOT_STARTING  | engine off; throttle without clutch stalls
//   ST_STARTING      | engine running, clutch engaged or idling
//   ST_MOVING        | driving in the latched gear; gear mismatch stalls
module manual_drive_ctrl
  import car_defs_pkg::*;
#(
  parameter int unsigned ODO_W      = 16,
  parameter int unsigned ODO_TICK   = 100000000,
  parameter int unsigned BLINK_HALF = 50000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               reverse,
  input  logic               brake,
  input  logic               clutch,
  input  logic               throttle,
  input  logic               left,
  input  logic               right,
  output logic               power_off,
  output logic [STATE_W-1:0] state,
  output logic               move_forward,
  output logic               move_backward,
  output logic               turn_left,
  output logic               turn_right,
  output logic               led_left,
  output logic               led_right,
  output logic [ODO_W-1:0]   odometer
);

  drive_state_t state_q, state_d;
  logic         gear_q, gear_d;
  logic         stall_d;
  logic         req_l, req_r;
  logic         rise_l, rise_r;
  logic         blink_l, blink_r;
  logic         odo_tick;

  assign state  = state_q;
  assign req_l  = enable & left & ~right;
  assign req_r  = enable & right & ~left;
  assign rise_l = req_l & ~turn_left;
  assign rise_r = req_r & ~turn_right;

  always_comb begin
    state_d = state_q;
    stall_d = 1'b0;
    // Gear can only change with the clutch down unless the car is not moving.
    gear_d  = (!enable || state_q != ST_MOVING || clutch) ? reverse : gear_q;
    if (!enable) begin
      state_d = ST_NOT_STARTING;
    end else begin
      case (state_q)
        ST_NOT_STARTING: begin
          if (throttle && !clutch)               stall_d = 1'b1;
          else if (throttle && clutch && !brake) state_d = ST_STARTING;
        end
        ST_STARTING: begin
          if (brake)                   state_d = ST_NOT_STARTING;
          else if (throttle && !clutch) state_d = ST_MOVING;
        end
        ST_MOVING: begin
          if (brake) begin
            state_d = ST_NOT_STARTING;
          end else if (!clutch && (reverse != gear_q)) begin
            stall_d = 1'b1;
            state_d = ST_NOT_STARTING;
          end else if (clutch || !throttle) begin
            state_d = ST_STARTING;
          end
        end
        default: state_d = ST_NOT_STARTING;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_NOT_STARTING;
      gear_q        <= 1'b0;
      power_off     <= 1'b0;
      move_forward  <= 1'b0;
      move_backward <= 1'b0;
      turn_left     <= 1'b0;
      turn_right    <= 1'b0;
      led_left      <= 1'b0;
      led_right     <= 1'b0;
      odometer      <= '0;
    end else begin
      state_q       <= state_d;
      gear_q        <= gear_d;
      power_off     <= stall_d;
      move_forward  <= (state_d == ST_MOVING) & ~gear_d;
      move_backward <= (state_d == ST_MOVING) & gear_d;
      turn_left     <= req_l;
      turn_right    <= req_r;
      led_left      <= !req_l ? 1'b0 : rise_l ? 1'b1 : (led_left ^ blink_l);
      led_right     <= !req_r ? 1'b0 : rise_r ? 1'b1 : (led_right ^ blink_r);
      if (odo_tick) odometer <= odometer + ODO_W'(1);
    end
  end

  // Prescaler keeps its partial count across stops so distance is not lost.
  tick_divider #(.MAX(ODO_TICK)) u_odo_div (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (enable && state_q == ST_MOVING),
    .clr   (1'b0),
    .tick  (odo_tick)
  );

  tick_divider #(.MAX(BLINK_HALF)) u_blink_l (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (req_l),
    .clr   (~req_l | rise_l),
    .tick  (blink_l)
  );

  tick_divider #(.MAX(BLINK_HALF)) u_blink_r (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (req_r),
    .clr   (~req_r | rise_r),
    .tick  (blink_r)
  );

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Self-checking bench for manual_drive_ctrl: directed vector table, hand
// sequences for blink/reset/enable corners, and a randomized model run.
module tb_manual_drive_ctrl;

  localparam int ODO_W      = 4;
  localparam int ODO_TICK   = 4;
  localparam int BLINK_HALF = 3;

  typedef struct packed {
    logic rst_n, en, rev, brk, clu, thr, lft, rgt;
  } in_t;

  typedef struct packed {
    in_t        i;
    logic [1:0] st;
    logic       po, mf, mb;
    logic [3:0] odo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, enable, reverse, brake, clutch, throttle, left, right;
  logic power_off, move_forward, move_backward;
  logic turn_left, turn_right, led_left, led_right;
  logic [1:0]       state;
  logic [ODO_W-1:0] odometer;
  logic [12:0]      dut_vec;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_st, m_mov, m_age_l, m_age_r;
  bit m_gear, m_po, m_mf, m_mb, m_tl, m_tr, m_ll, m_lr;

  vec_t tbl[$];
  logic [9:0] blink_pat;
  int   odo_hold;

  manual_drive_ctrl #(.ODO_W(ODO_W), .ODO_TICK(ODO_TICK), .BLINK_HALF(BLINK_HALF)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .reverse       (reverse),
    .brake         (brake),
    .clutch        (clutch),
    .throttle      (throttle),
    .left          (left),
    .right         (right),
    .power_off     (power_off),
    .state         (state),
    .move_forward  (move_forward),
    .move_backward (move_backward),
    .turn_left     (turn_left),
    .turn_right    (turn_right),
    .led_left      (led_left),
    .led_right     (led_right),
    .odometer      (odometer)
  );

  always #5 clk = ~clk;

  assign dut_vec = {power_off, state, move_forward, move_backward,
                    turn_left, turn_right, led_left, led_right, odometer};

  function automatic logic [3:0] m_odo();
    return 4'((m_mov / ODO_TICK) % 16);
  endfunction

  function automatic logic [12:0] m_vec();
    return {m_po, 2'(m_st), m_mf, m_mb, m_tl, m_tr, m_ll, m_lr, m_odo()};
  endfunction

  task automatic m_step(input in_t x);
    int nst;
    bit ng, po, rl, rr;
    if (!x.rst_n) begin
      m_st = 0; m_gear = 0; m_mov = 0; m_age_l = -1; m_age_r = -1;
      m_po = 0; m_mf = 0; m_mb = 0; m_tl = 0; m_tr = 0; m_ll = 0; m_lr = 0;
      return;
    end
    if (x.en && m_st == 2) m_mov++;
    ng  = (!x.en || m_st != 2 || x.clu) ? x.rev : m_gear;
    nst = m_st;
    po  = 0;
    if (!x.en) nst = 0;
    else if (m_st == 0) begin
      if (x.thr && !x.clu) po = 1;
      else if (x.thr && x.clu && !x.brk) nst = 1;
    end else if (m_st == 1) begin
      if (x.brk) nst = 0;
      else if (x.thr && !x.clu) nst = 2;
    end else begin
      if (x.brk) nst = 0;
      else if (!x.clu && (x.rev != m_gear)) begin po = 1; nst = 0; end
      else if (x.clu || !x.thr) nst = 1;
    end
    rl = x.en && x.lft && !x.rgt;
    rr = x.en && x.rgt && !x.lft;
    m_age_l = !rl ? -1 : (m_age_l < 0 ? 0 : m_age_l + 1);
    m_age_r = !rr ? -1 : (m_age_r < 0 ? 0 : m_age_r + 1);
    m_ll = rl && ((m_age_l / BLINK_HALF) % 2 == 0);
    m_lr = rr && ((m_age_r / BLINK_HALF) % 2 == 0);
    m_st = nst; m_gear = ng; m_po = po;
    m_mf = (nst == 2) && !ng;
    m_mb = (nst == 2) && ng;
    m_tl = rl; m_tr = rr;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input in_t x, input string name);
    {rst_n, enable, reverse, brake, clutch, throttle, left, right} = x;
    @(posedge clk);
    m_step(x);
    #1;
    check(name, 32'(dut_vec), 32'(m_vec()));
  endtask

  function automatic vec_t mk(input logic [7:0] i, input logic [1:0] st,
                              input logic po, input logic mf, input logic mb,
                              input logic [3:0] odo);
    vec_t v;
    v.i = in_t'(i); v.st = st; v.po = po; v.mf = mf; v.mb = mb; v.odo = odo;
    return v;
  endfunction

  initial begin
    blink_pat = 10'b1110001110;

    // Startup stall, start, move 8 cycles, stall on gear change, reverse via clutch, brake
    tbl.push_back(mk(8'b1100_0100, 2'd0, 1, 0, 0, 0));
    tbl.push_back(mk(8'b1100_0000, 2'd0, 0, 0, 0, 0));
    tbl.push_back(mk(8'b1100_1100, 2'd1, 0, 0, 0, 0));
    tbl.push_back(mk(8'b1100_0100, 2'd2, 0, 1, 0, 0));
    tbl.push_back(mk(8'b1100_0100, 2'd2, 0, 1, 0, 0));
    tbl.push_back(mk(8'b1100_0100, 2'd2, 0, 1, 0, 0));
    tbl.push_back(mk(8'b1100_0100, 2'd2, 0, 1, 0, 0));
    tbl.push_back(mk(8'b1100_0100, 2'd2, 0, 1, 0, 1));
    tbl.push_back(mk(8'b1100_0100, 2'd2, 0, 1, 0, 1));
    tbl.push_back(mk(8'b1100_0100, 2'd2, 0, 1, 0, 1));
    tbl.push_back(mk(8'b1100_0100, 2'd2, 0, 1, 0, 1));
    tbl.push_back(mk(8'b1100_0100, 2'd2, 0, 1, 0, 2));
    tbl.push_back(mk(8'b1110_0100, 2'd0, 1, 0, 0, 2));
    tbl.push_back(mk(8'b1100_0000, 2'd0, 0, 0, 0, 2));
    tbl.push_back(mk(8'b1100_1100, 2'd1, 0, 0, 0, 2));
    tbl.push_back(mk(8'b1100_0100, 2'd2, 0, 1, 0, 2));
    tbl.push_back(mk(8'b1110_1100, 2'd1, 0, 0, 0, 2));
    tbl.push_back(mk(8'b1110_0100, 2'd2, 0, 0, 1, 2));
    tbl.push_back(mk(8'b1110_0100, 2'd2, 0, 0, 1, 2));
    tbl.push_back(mk(8'b1101_0100, 2'd0, 0, 0, 0, 3));
    tbl.push_back(mk(8'b1100_0000, 2'd0, 0, 0, 0, 3));

    {rst_n, enable, reverse, brake, clutch, throttle, left, right} = 8'h00;
    m_step(in_t'(8'h00));
    cyc(in_t'(8'b0100_0000), "reset");
    cyc(in_t'(8'b0100_0000), "reset");
    check("reset_outputs", 32'(dut_vec), 32'd0);

    foreach (tbl[k]) begin
      cyc(tbl[k].i, "tbl_model");
      check($sformatf("tbl_row%0d", k), 32'({state, power_off, move_forward, move_backward, odometer}),
            32'({tbl[k].st, tbl[k].po, tbl[k].mf, tbl[k].mb, tbl[k].odo}));
    end

    // Left blink pattern, then both requests cancel, then restart on a new rise
    for (int k = 0; k < 10; k++) begin
      cyc(in_t'(8'b1100_0010), "blink_model");
      check($sformatf("led_left_c%0d", k), 32'({turn_left, led_left}), 32'({1'b1, blink_pat[9-k]}));
    end
    cyc(in_t'(8'b1100_0011), "both_model");
    check("both_turns_off", 32'({turn_left, turn_right, led_left, led_right}), 32'd0);
    cyc(in_t'(8'b1100_0010), "restart_model");
    check("blink_restart", 32'({turn_left, led_left}), 32'b11);
    cyc(in_t'(8'b1100_0000), "drop_model");
    check("led_drop", 32'({turn_left, led_left}), 32'd0);

    // Reach odometer 5 in MOVING, then reset for one cycle
    cyc(in_t'(8'b1100_1100), "to_start");
    cyc(in_t'(8'b1100_0100), "to_move");
    for (int k = 0; k < 40 && m_odo() != 4'd5; k++) cyc(in_t'(8'b1100_0100), "odo_run");
    check("odo_at_5", 32'({state, odometer}), 32'({2'd2, 4'd5}));
    cyc(in_t'(8'b0100_0100), "mid_reset_model");
    check("mid_reset_all_zero", 32'(dut_vec), 32'd0);

    // Drop enable while MOVING: engine off, odometer holds
    cyc(in_t'(8'b1100_1100), "to_start2");
    cyc(in_t'(8'b1100_0100), "to_move2");
    for (int k = 0; k < 5; k++) cyc(in_t'(8'b1100_0100), "move2");
    odo_hold = int'(m_odo());
    cyc(in_t'(8'b1000_0100), "disable_model");
    check("disable_state_odo", 32'({state, move_forward, odometer}), 32'({2'd0, 1'b0, 4'(odo_hold)}));
    cyc(in_t'(8'b1000_0110), "disable2_model");
    check("disable_hold", 32'({state, turn_left, led_left, odometer}), 32'({2'd0, 2'b00, 4'(odo_hold)}));

    // Randomized run against the model
    begin
      in_t x;
      x = in_t'(8'b1100_0000);
      for (int k = 0; k < 3000; k++) begin
        x.rst_n = ($urandom_range(0, 99) != 0);
        x.en    = ($urandom_range(0, 24) != 0);
        x.brk   = ($urandom_range(0, 9) == 0);
        x.clu   = ($urandom_range(0, 2) == 0);
        x.thr   = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 11) == 0) x.rev = ~x.rev;
        if ($urandom_range(0, 9) == 0)  x.lft = ~x.lft;
        if ($urandom_range(0, 9) == 0)  x.rgt = ~x.rgt;
        cyc(x, "random");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
